// File: rtl/snow64_bfloat16_mul_arbiter.sv
// Round-robin front end that time-shares one Snow64BFloat16Mul instance
// between NUM_REQ requesters. One multiply is in flight at a time. The
// result goes back on a shared response bus, tagged with the owner's index.
// All outputs are registered.
module snow64_bfloat16_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [15:0]           resp_data,
    output logic                  busy,
    output logic                  mul_start,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    input  logic                  mul_data_valid,
    input  logic [15:0]           mul_data
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [ID_WIDTH:0]   NUM_REQ_EXT = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID     = ID_WIDTH'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic                 guard_q, guard_d;
    logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]  grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 mul_start_q, mul_start_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;
    logic [ID_WIDTH-1:0]  resp_id_q, resp_id_d;
    logic [15:0]          resp_data_q, resp_data_d;
    logic [15:0]          mul_a_q, mul_a_d;
    logic [15:0]          mul_b_q, mul_b_d;

    // Arbitration helpers
    logic                 done;
    logic                 can_grant;
    logic [ID_WIDTH-1:0]  ptr_after;
    logic [ID_WIDTH-1:0]  arb_base;
    logic [ID_WIDTH-1:0]  win_id;
    logic [ID_WIDTH-1:0]  win_off;
    logic [ID_WIDTH:0]    win_sum;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [15:0]          op_a [NUM_REQ];
    logic [15:0]          op_b [NUM_REQ];

    // The multiplier's valid is only meaningful while waiting. Elsewhere it
    // may be a sticky leftover from an earlier result, so it is ignored.
    assign done = (state_q == ST_WAIT) && mul_data_valid;

    // The completing cycle also acts as an IDLE cycle. This lets the next
    // grant coincide with the response, so back-to-back operations run
    // every 3 cycles.
    assign can_grant = ((state_q == ST_IDLE) || done) && (|req_valid);

    assign ptr_after = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

    // Once the pointer moves past the finishing owner, arbitration in the
    // same cycle must already use the advanced pointer.
    assign arb_base = done ? ptr_after : ptr_q;

    // Rotate the request vector so that bit 0 is the pointer position.
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = req_dbl[{1'b0, arb_base} +: NUM_REQ];

    // Split the operand buses per requester and build the one-hot accept
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_a[gi]        = req_a[16*gi +: 16];
        assign op_b[gi]        = req_b[16*gi +: 16];
        assign req_ready_d[gi] = can_grant && (win_id == ID_WIDTH'(gi));
    end

    // First requesting index at or above the pointer, wrapping modulo NUM_REQ
    always_comb begin
        win_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = ID_WIDTH'(k);
            end
        end
        win_sum = {1'b0, arb_base} + {1'b0, win_off};
        if (win_sum >= NUM_REQ_EXT) begin
            win_sum = win_sum - NUM_REQ_EXT;
        end
        win_id = win_sum[ID_WIDTH-1:0];
    end

    // State and output registers; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            guard_q      <= 1'b0;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            req_ready_q  <= '0;
            mul_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            req_ready_q  <= req_ready_d;
            mul_start_q  <= mul_start_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            busy_q       <= busy_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
        end
    end

    // Next-state logic. INIT gives an unreset multiplier two cycles to drain.
    always_comb begin
        state_d = state_q;
        guard_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                guard_d = guard_q + 1'b1;
                if (guard_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (can_grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_d = can_grant ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Next values of the registered outputs and the grant bookkeeping
    always_comb begin
        mul_start_d  = can_grant;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        grant_id_d   = grant_id_q;
        resp_valid_d = done;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        ptr_d        = ptr_q;
        busy_d       = (state_d != ST_IDLE);
        if (can_grant) begin
            mul_a_d    = op_a[win_id];
            mul_b_d    = op_b[win_id];
            grant_id_d = win_id;
        end
        if (done) begin
            resp_id_d   = grant_id_q;
            resp_data_d = mul_data;
            ptr_d       = ptr_after;
        end
    end

    assign req_ready  = req_ready_q;
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_snow64_bfloat16_mul_arbiter.sv
// Bench for snow64_bfloat16_mul_arbiter. It contains a behavioural stand-in
// for the multiplier, a transaction-level reference model, table-driven
// vectors, and hand-written corner-case sequences.
module tb_snow64_bfloat16_mul_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_a = '0;
    logic [16*N-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [15:0]     resp_data;
    logic            busy;
    logic            mul_start;
    logic [15:0]     mul_a;
    logic [15:0]     mul_b;
    logic            mul_data_valid = 1'b0;
    logic [15:0]     mul_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always #5 clk = ~clk;

    snow64_bfloat16_mul_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_data_valid(mul_data_valid), .mul_data(mul_data)
    );

    // bfloat16 product of normal numbers, truncated; zero/underflow gives signed zero
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] p;
        logic [6:0]  m;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {s, 15'h0};
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 1;
        end else begin
            m = p[13:7];
        end
        if (e <= 0) return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        return {s, e[7:0], m};
    endfunction

    // Multiplier stand-in: no reset. It samples start, clears its sticky
    // valid, and sets the valid again one cycle later.
    logic        mpend = 1'b0;
    logic [15:0] mpa = '0, mpb = '0;
    always @(posedge clk) begin
        if (mul_start) begin
            mul_data_valid <= 1'b0;
            mpend          <= 1'b1;
            mpa            <= mul_a;
            mpb            <= mul_b;
        end else if (mpend) begin
            mul_data_valid <= 1'b1;
            mul_data       <= bf16_mul(mpa, mpb);
            mpend          <= 1'b0;
        end
    end

    // Reference model. A grant is followed by its response 3 edges later.
    // The arbiter is free again on the response edge. Two edges after
    // reset give no grant.
    int          m_cd = 0, m_init = 0, m_ptr = 0, m_id = 0;
    logic [15:0] m_data = '0;
    logic [N-1:0] e_ready = '0;
    logic        e_start = 0, e_rv = 0, e_busy = 0;
    int          e_rid = 0;
    logic [15:0] e_rdata = '0, e_ma = '0, e_mb = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cd = 0; m_init = 0; m_ptr = 0;
            e_ready = '0; e_start = 0; e_rv = 0; e_busy = 0;
        end else begin
            e_ready = '0; e_start = 0; e_rv = 0;
            if (m_init == 0) begin
                m_init = 1; e_busy = 1;
            end else if (m_init == 1) begin
                m_init = 2; e_busy = 0;
            end else begin
                if (m_cd > 0) begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) begin
                        e_rv = 1; e_rid = m_id; e_rdata = m_data;
                        m_ptr = (m_id + 1) % N;
                    end
                end
                if (m_cd == 0 && req_valid != '0) begin
                    for (int k = 0; k < N; k++) begin
                        if (req_valid[(m_ptr + k) % N]) begin
                            m_id = (m_ptr + k) % N;
                            break;
                        end
                    end
                    e_ready[m_id] = 1'b1;
                    e_start = 1;
                    e_ma = req_a[16*m_id +: 16];
                    e_mb = req_b[16*m_id +: 16];
                    m_data = bf16_mul(e_ma, e_mb);
                    m_cd = 3;
                end
                e_busy = (m_cd != 0);
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        cyc_n++;
        checks++;
        if (req_ready !== e_ready || mul_start !== e_start || resp_valid !== e_rv ||
            busy !== e_busy ||
            (e_rv && (int'(resp_id) != e_rid || resp_data !== e_rdata)) ||
            (e_start && (mul_a !== e_ma || mul_b !== e_mb))) begin
            errors++;
            $display("FAIL model cyc=%0d got/exp ready=%b/%b start=%b/%b rv=%b/%b busy=%b/%b id=%0d/%0d data=%h/%h a=%h/%h b=%h/%h",
                     cyc_n, req_ready, e_ready, mul_start, e_start, resp_valid, e_rv,
                     busy, e_busy, resp_id, e_rid, resp_data, e_rdata, mul_a, e_ma, mul_b, e_mb);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int onehot_id(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One request on requester id: check the accept pulse, the latency and the result
    task automatic run_vec(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input logic [15:0] mask);
        int t;
        int lat;
        logic [N-1:0] oh;
        oh = '0; oh[id] = 1'b1;
        @(negedge clk); #1;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_valid[id] = 1'b1;
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!req_ready[id] && t < 20);
        chk("vec_ready_onehot", 64'(req_ready), 64'(oh));
        chk("vec_start", 64'(mul_start), 64'd1);
        #1 req_valid[id] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
            if (lat == 1) chk("vec_ready_one_cycle", 64'(req_ready), 64'd0);
        end while (!resp_valid && lat < 10);
        chk("vec_latency", 64'(lat), 64'd3);
        chk("vec_resp_id", 64'(resp_id), 64'(id));
        chk("vec_resp_data", 64'(resp_data & mask), 64'(exp));
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [15:0] mask;
    } vec_t;

    vec_t vecs[6];
    int   gq[$];
    int   rt[$];
    int   rid[$];
    logic [15:0] rdq[$];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit busy_ok;
        bit started;
        int t;
        int g;
        int fair_exp[6];

        vecs[0] = '{0, 16'h3F80, 16'h4000, 16'h4000, 16'hFFFF};   // 1 * 2
        vecs[1] = '{2, 16'hBF80, 16'h4000, 16'hC000, 16'hFFFF};   // -1 * 2
        vecs[2] = '{2, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF};   // 0 * 2
        vecs[3] = '{1, 16'h3FC0, 16'h3FC0, 16'h4010, 16'hFFFF};   // 1.5 * 1.5
        vecs[4] = '{3, 16'h4040, 16'h4080, 16'h4140, 16'hFFFF};   // 3 * 4
        vecs[5] = '{0, 16'hC000, 16'hC000, 16'h4080, 16'hFFFF};   // -2 * -2
        fair_exp = '{1, 3, 1, 3, 1, 3};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {req_ready, resp_valid, resp_id, resp_data, busy, mul_start, mul_a, mul_b}, 64'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven single requests; the sticky valid left over between them exercises stale handling
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].mask);
        end

        // Stale valid: idle cycles with the multiplier valid still high
        repeat (4) begin
            @(negedge clk);
            chk("stale_no_resp", 64'({mul_data_valid, resp_valid}), 64'b10);
        end
        run_vec(2, 16'h3F80, 16'h4000, 16'h4000, 16'hFFFF);

        // All four requesters at once after reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = 16'h3FC0;
            req_b[16*i +: 16] = 16'h3FC0;
        end
        req_valid = '1;
        busy_ok = 1; started = 0;
        for (t = 0; t < 60 && rt.size() < 4; t++) begin
            @(negedge clk);
            if (resp_valid) begin
                rt.push_back(t); rid.push_back(int'(resp_id)); rdq.push_back(resp_data);
            end
            if (started && rt.size() < 4 && !busy) busy_ok = 0;
            if (req_ready != '0) begin
                started = 1;
                g = onehot_id(req_ready);
                gq.push_back(g);
                #1 req_valid[g] = 1'b0;
            end
        end
        chk("all4_grant_count", 64'(gq.size()), 64'd4);
        chk("all4_resp_count", 64'(rt.size()), 64'd4);
        for (int k = 0; k < gq.size() && k < 4; k++) chk("all4_grant_order", 64'(gq[k]), 64'(k));
        for (int k = 0; k < rt.size(); k++) begin
            chk("all4_resp_id", 64'(rid[k]), 64'(k));
            chk("all4_resp_data", 64'(rdq[k]), 64'h4010);
            if (k > 0) chk("all4_resp_spacing", 64'(rt[k] - rt[k-1]), 64'd3);
        end
        chk("all4_busy_held", 64'(busy_ok), 64'd1);

        // Fairness: requesters 1 and 3 held continuously
        do_reset();
        req_a[16 +: 16] = 16'h3F80; req_b[16 +: 16] = 16'h4000;
        req_a[48 +: 16] = 16'h4000; req_b[48 +: 16] = 16'h4000;
        req_valid = 4'b1010;
        gq.delete();
        for (t = 0; t < 80 && gq.size() < 6; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = onehot_id(req_ready);
                gq.push_back(g);
                #1;
                req_a[16*g +: 16] = 16'($urandom_range(16'h3F00, 16'h40FF));
            end
        end
        #1 req_valid = '0;
        chk("fair_grant_count", 64'(gq.size()), 64'd6);
        for (int k = 0; k < gq.size(); k++) chk("fair_order", 64'(gq[k]), 64'(fair_exp[k]));
        repeat (4) @(negedge clk);

        // Reset while waiting for the multiplier
        @(negedge clk); #1;
        req_a[32 +: 16] = 16'h3F80; req_b[32 +: 16] = 16'h4000; req_valid[2] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready[2] && t < 20);
        chk("rstwait_grant", 64'(req_ready), 64'b0100);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        req_a[0 +: 16] = 16'h4000; req_b[0 +: 16] = 16'h4000; req_valid[0] = 1'b1;
        #1 chk("rstwait_outputs_zero", {req_ready, resp_valid, resp_id, resp_data, busy, mul_start, mul_a, mul_b}, 64'd0);
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstwait_init_no_grant", 64'({req_ready, resp_valid}), 64'd0);
        end
        @(negedge clk);
        chk("rstwait_first_grant", 64'(req_ready), 64'b0001);
        #1 req_valid[0] = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!resp_valid && t < 10);
        chk("rstwait_latency", 64'(t), 64'd3);
        chk("rstwait_resp", 64'({resp_id, resp_data}), 64'({2'd0, 16'h4080}));

        // Randomised traffic against the reference model, with one mid-run reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 300) rst = 1'b1;
            if (cyc == 302) rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (e_ready[i]) begin
                        req_valid[i] = 1'($urandom_range(0, 1));
                        req_a[16*i +: 16] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
                        req_b[16*i +: 16] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
                    end else if ($urandom_range(0, 19) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[16*i +: 16] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
                    req_b[16*i +: 16] = {1'($urandom), 8'($urandom_range(100, 150)), 7'($urandom)};
                end
            end
        end
        #1 req_valid = '0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
